hazard_unit: RTL

- Pipeline hazard controller for the 5-stage core, working alongside the forwarding controller.
- Covers the cases forwarding cannot resolve:
  - load-use dependencies (loads are never forwarded from EX or MEM);
  - data-memory wait states;
  - control redirects from taken branches/jumps.
- Drives stall, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers via a small FSM with a bubble counter.

---
 rtl/core_pkg.sv | 28 ++
 rtl/hazard_perf_cnt.sv | 21 ++
 rtl/hazard_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared pipeline types and hazard-controller constants for the 5-stage core.
// Pure declarations: no logic, no latency, no flow control.
// Loads are recognised by the top bit of mem_op alone; the low bits carry the access size.
package core;

    localparam int   REG_W          = 5;
    localparam int   MEM_OP_BITS    = 4;
    localparam logic LOAD_PRFX      = 1'b1;
    localparam int   HZ_MAX_BUBBLES = 3;

    typedef struct packed {
        logic [REG_W-1:0]       rs1;
        logic [REG_W-1:0]       rs2;
        logic [REG_W-1:0]       rd;
        logic [MEM_OP_BITS-1:0] mem_op;
    } pipeline_bus_t;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_LU_STALL,
        HZ_MEM_WAIT
    } hazard_state_t;

    function automatic logic is_load(input pipeline_bus_t bus);
        return bus.mem_op[MEM_OP_BITS-1] == LOAD_PRFX;
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter for the hazard unit's performance statistics.
// Latency: count visible one cycle after inc; holds at all-ones.
// No backpressure: inc is sampled every cycle.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, data-memory wait stalls, branch flushes.
// Latency: controls are combinational (zero cycles); FSM state updates on posedge clk.
// Backpressure: mem wait freezes PC..EX/MEM; perf counters only with HAZARD_PERF_CNT_EN.
module hazard_unit
    import core::*;
#(
    parameter int LOAD_USE_BUBBLES = 2,
    parameter int CNT_W            = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  core::pipeline_bus_t id_bus_i,
    input  core::pipeline_bus_t ex_bus_i,
    input  logic               br_taken_i,
    input  logic               dmem_valid_i,
    input  logic               dmem_ready_i,
    output logic               pc_stall_o,
    output logic               if_id_stall_o,
    output logic               if_id_flush_o,
    output logic               id_ex_bubble_o,
    output logic               id_ex_stall_o,
    output logic               ex_mem_stall_o,
    output logic [CNT_W-1:0]   lu_stall_cnt_o,
    output logic [CNT_W-1:0]   mem_stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    localparam int LU_W = $clog2(HZ_MAX_BUBBLES + 1);
    localparam logic [LU_W-1:0] LU_RELOAD = LU_W'(LOAD_USE_BUBBLES - 1);

    hazard_state_t   state, state_nxt;
    logic [LU_W-1:0] lu_cnt, lu_cnt_nxt;

    logic lu_hit, mem_wait;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_stall, ex_mem_stall;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{id_bus_i.rd, id_bus_i.mem_op, ex_bus_i.rs1, ex_bus_i.rs2,
                               ex_bus_i.mem_op[MEM_OP_BITS-2:0]};

    assign lu_hit   = (ex_bus_i.rd != '0) && is_load(ex_bus_i) &&
                      ((id_bus_i.rs1 == ex_bus_i.rd) || (id_bus_i.rs2 == ex_bus_i.rd));
    assign mem_wait = dmem_valid_i && !dmem_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= HZ_RUN;
            lu_cnt <= '0;
        end else begin
            state  <= state_nxt;
            lu_cnt <= lu_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lu_cnt_nxt   = lu_cnt;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;

        unique case (state)
            HZ_RUN: begin
                if (mem_wait) begin
                    {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} = '1;
                    lu_cnt_nxt = '0;
                    state_nxt  = HZ_MEM_WAIT;
                end else if (br_taken_i) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (lu_hit) begin
                    {pc_stall, if_id_stall, id_ex_bubble} = '1;
                    if (LOAD_USE_BUBBLES > 1) begin
                        lu_cnt_nxt = LU_RELOAD;
                        state_nxt  = HZ_LU_STALL;
                    end
                end
            end
            HZ_LU_STALL: begin
                if (mem_wait) begin
                    {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} = '1;
                    state_nxt = HZ_MEM_WAIT;
                end else if (br_taken_i) begin
                    // The stalled consumer sits on the wrong path, so drop the remaining bubbles.
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    lu_cnt_nxt   = '0;
                    state_nxt    = HZ_RUN;
                end else begin
                    {pc_stall, if_id_stall, id_ex_bubble} = '1;
                    lu_cnt_nxt = lu_cnt - LU_W'(1);
                    if (lu_cnt == LU_W'(1)) begin
                        state_nxt = HZ_RUN;
                    end
                end
            end
            HZ_MEM_WAIT: begin
                if (mem_wait) begin
                    {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} = '1;
                end else begin
                    state_nxt = (lu_cnt != '0) ? HZ_LU_STALL : HZ_RUN;
                end
            end
            default: begin
                state_nxt  = HZ_RUN;
                lu_cnt_nxt = '0;
            end
        endcase
    end

    // Controls are forced low during reset, whatever the inputs are doing.
    assign pc_stall_o     = rst && pc_stall;
    assign if_id_stall_o  = rst && if_id_stall;
    assign if_id_flush_o  = rst && if_id_flush;
    assign id_ex_bubble_o = rst && id_ex_bubble;
    assign id_ex_stall_o  = rst && id_ex_stall;
    assign ex_mem_stall_o = rst && ex_mem_stall;

`ifdef HAZARD_PERF_CNT_EN
    logic lu_inc, mem_inc, flush_inc;

    assign lu_inc    = pc_stall_o && id_ex_bubble_o;
    assign mem_inc   = ex_mem_stall_o;
    assign flush_inc = if_id_flush_o;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk (clk),
        .rst (rst),
        .inc (lu_inc),
        .cnt (lu_stall_cnt_o)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_mem_cnt (
        .clk (clk),
        .rst (rst),
        .inc (mem_inc),
        .cnt (mem_stall_cnt_o)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt_o)
    );
`else
    assign lu_stall_cnt_o  = '0;
    assign mem_stall_cnt_o = '0;
    assign flush_cnt_o     = '0;
`endif

endmodule
